// File: rtl/hwpe_stream_sink_realign_wr.sv
// Write-side stream realigner: shifts an aligned word stream by k bytes and emits per-byte strobes.
// Optional status outputs (busy_o, words_o) are enabled with `define HWPE_SINK_REALIGN_STATUS_EN.
module hwpe_stream_sink_realign_wr #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  localparam int unsigned NB        = DATA_WIDTH / 8,
  localparam int unsigned OW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [OW-1:0]         offset_i,
  input  logic [LEN_WIDTH-1:0]  line_length_i,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] stream_i_data,
  input  logic                  stream_i_valid,
  output logic                  stream_i_ready,
  output logic [DATA_WIDTH-1:0] stream_o_data,
  output logic [NB-1:0]         stream_o_strb,
  output logic                  stream_o_valid,
  input  logic                  stream_o_ready,
`ifdef HWPE_SINK_REALIGN_STATUS_EN
  output logic                  busy_o,
  output logic [LEN_WIDTH:0]    words_o,
`endif
  output logic [1:0]            state_o
);

  // Handshake: a word moves when valid && ready in the same cycle; once valid is
  // raised, data/strb hold until ready, and valid never depends on ready.

  localparam int unsigned SHW = OW + 4;
  localparam logic [NB-1:0] STRB_ALL = {NB{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [OW-1:0]         k_q;
  logic [DATA_WIDTH-1:0] prev_q;

  logic [SHW-1:0]        sh_lo;
  logic [SHW-1:0]        sh_hi;
  logic                  cnt_last;
  logic                  in_hs;
  logic                  accept_start;

  assign sh_lo        = SHW'({k_q, 3'b000});
  assign sh_hi        = SHW'(DATA_WIDTH) - sh_lo;
  assign cnt_last     = (cnt_q == len_q - LEN_WIDTH'(1));
  assign in_hs        = (state_q == RUN) && stream_i_valid && stream_o_ready;
  assign accept_start = (state_q == IDLE) && start_i;
  assign state_o      = state_q;

  always_comb begin
    state_d        = state_q;
    stream_o_valid = 1'b0;
    stream_i_ready = 1'b0;
    stream_o_data  = '0;
    stream_o_strb  = '0;
    done_o         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (line_length_i == '0) ? DONE : RUN;
      end
      RUN: begin
        stream_o_valid = stream_i_valid;
        stream_i_ready = stream_o_ready;
        // k==0 skips the carry term so no full-width shift is ever formed
        if (k_q == '0) stream_o_data = stream_i_data;
        else stream_o_data = (stream_i_data << sh_lo) | (prev_q >> sh_hi);
        stream_o_strb = (cnt_q == '0) ? (STRB_ALL << k_q) : STRB_ALL;
        if (in_hs && cnt_last) state_d = (k_q != '0) ? FLUSH : DONE;
      end
      FLUSH: begin
        stream_o_valid = 1'b1;
        stream_o_data  = prev_q >> sh_hi;
        stream_o_strb  = ~(STRB_ALL << k_q);
        if (stream_o_ready) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        k_q    <= offset_i;
        len_q  <= line_length_i;
        cnt_q  <= '0;
        prev_q <= '0;
      end else if (in_hs) begin
        prev_q <= stream_i_data;
        if (!cnt_last) cnt_q <= cnt_q + LEN_WIDTH'(1);
      end
    end
  end

`ifdef HWPE_SINK_REALIGN_STATUS_EN
  logic [LEN_WIDTH:0] words_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      words_q <= '0;
    end else if (accept_start) begin
      words_q <= '0;
    end else if (stream_o_valid && stream_o_ready) begin
      words_q <= words_q + (LEN_WIDTH+1)'(1);
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign words_o = words_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_sink_realign_wr.sv
// Bench for hwpe_stream_sink_realign_wr: cycle vector table, hand-written clear sequence,
// and randomized lines checked against a byte-image reference model.
module tb_hwpe_stream_sink_realign_wr;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    offset_i = '0;
  logic [LW-1:0] line_length_i = '0;
  logic          done_o;
  logic [DW-1:0] stream_i_data = '0;
  logic          stream_i_valid = 1'b0;
  logic          stream_i_ready;
  logic [DW-1:0] stream_o_data;
  logic [NB-1:0] stream_o_strb;
  logic          stream_o_valid;
  logic          stream_o_ready = 1'b0;
  logic [1:0]    state_o;
`ifdef HWPE_SINK_REALIGN_STATUS_EN
  logic          busy_o;
  logic [LW:0]   words_o;
`endif

  hwpe_stream_sink_realign_wr #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .offset_i      (offset_i),
    .line_length_i (line_length_i),
    .done_o        (done_o),
    .stream_i_data (stream_i_data),
    .stream_i_valid(stream_i_valid),
    .stream_i_ready(stream_i_ready),
    .stream_o_data (stream_o_data),
    .stream_o_strb (stream_o_strb),
    .stream_o_valid(stream_o_valid),
    .stream_o_ready(stream_o_ready),
`ifdef HWPE_SINK_REALIGN_STATUS_EN
    .busy_o        (busy_o),
    .words_o       (words_o),
`endif
    .state_o       (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_mem [0:63];
  logic [DW-1:0] exp_q [$];
  logic [NB-1:0] exp_s_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the line's bytes land at byte positions k .. k+NB*len-1 of a
  // destination image; each output word is one NB-byte slice of that image.
  task automatic build_model(input int k, input int len);
    int nbytes, nout;
    logic [DW-1:0] d, w;
    logic [NB-1:0] s;
    exp_q.delete();
    exp_s_q.delete();
    nbytes = k + NB * len;
    nout   = (nbytes + NB - 1) / NB;
    for (int j = 0; j < nout; j++) begin
      d = '0;
      s = '0;
      for (int b = 0; b < NB; b++) begin
        int p;
        p = j * NB + b;
        if (p >= k && p < nbytes) begin
          w = in_mem[(p - k) / NB] >> (8 * ((p - k) % NB));
          d[8*b +: 8] = w[7:0];
          s[b] = 1'b1;
        end
      end
      exp_q.push_back(d);
      exp_s_q.push_back(s);
    end
  endtask

  // Driver + scoreboard for one line; called just after a negedge, returns just after one.
  task automatic run_line(input int k, input int len, input int rdy_pct, input int vld_pct,
                          input bit poke_start);
    int idx, n_exp;
    bit held, hold_o, expect_done, done_seen;
    logic [DW-1:0] hold_d;
    logic [NB-1:0] hold_s;
    build_model(k, len);
    n_exp = exp_q.size();
    start_i = 1'b1; offset_i = 2'(k); line_length_i = LW'(len);
    stream_i_valid = 1'b0; stream_o_ready = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    idx = 0; held = 0; hold_o = 0; expect_done = 0; done_seen = 0;
    hold_d = '0; hold_s = '0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      offset_i = 2'($urandom_range(3));
      line_length_i = LW'($urandom_range(7));
      if (!held) stream_i_valid = (idx < len) && ($urandom_range(99) < vld_pct);
      stream_i_data  = (idx < len) ? in_mem[idx] : DW'($urandom);
      stream_o_ready = ($urandom_range(99) < rdy_pct);
      start_i = poke_start && ($urandom_range(1) == 1);
      #1;
`ifdef HWPE_SINK_REALIGN_STATUS_EN
      chk("busy_in_line", busy_o, 1'b1);
`endif
      if (expect_done) chk("done_timing", done_o, 1'b1);
      expect_done = 0;
      if (done_o) begin
        done_seen = 1;
        chk("words_left_at_done", exp_q.size(), 0);
        chk("valid_at_done", stream_o_valid, 1'b0);
      end else if (stream_o_valid) begin
        if (hold_o) begin
          chk("stable_data", stream_o_data, hold_d);
          chk("stable_strb", stream_o_strb, hold_s);
        end
        if (exp_q.size() == 0) chk("extra_word", stream_o_valid, 1'b0);
        else if (stream_o_ready) begin
          chk("out_data", stream_o_data, exp_q.pop_front());
          chk("out_strb", stream_o_strb, exp_s_q.pop_front());
          expect_done = (exp_q.size() == 0);
        end
      end
      held   = stream_i_valid && !stream_i_ready;
      if (stream_i_valid && stream_i_ready) idx++;
      hold_o = stream_o_valid && !stream_o_ready;
      hold_d = stream_o_data;
      hold_s = stream_o_strb;
      @(negedge clk);
    end
    chk("done_seen", done_seen, 1'b1);
    chk("in_consumed", idx, len);
    start_i = 1'b0; stream_i_valid = 1'b0;
    #1;
    chk("done_one_cycle", done_o, 1'b0);
    chk("idle_after_done", state_o, 2'd0);
`ifdef HWPE_SINK_REALIGN_STATUS_EN
    chk("words_count", words_o, n_exp);
    chk("busy_cleared", busy_o, 1'b0);
`endif
    @(negedge clk);
  endtask

  typedef struct {
    bit            start;
    logic [1:0]    k;
    logic [LW-1:0] len;
    logic [DW-1:0] din;
    bit            vin;
    bit            rout;
    bit            exp_vo;
    bit            exp_ri;
    logic [DW-1:0] exp_d;
    logic [NB-1:0] exp_s;
    bit            exp_done;
  } vec_t;

  vec_t vecs [0:16];

  initial begin
    // k=0, L=3 with one stall and a start poke during RUN
    vecs[0]  = '{1, 2'd0, 16'd3, 32'h0,        0, 0, 0, 0, 32'h0,        4'h0, 0};
    vecs[1]  = '{0, 2'd0, 16'd0, 32'hA0A1A2A3, 1, 0, 1, 0, 32'hA0A1A2A3, 4'hF, 0};
    vecs[2]  = '{0, 2'd0, 16'd0, 32'hA0A1A2A3, 1, 1, 1, 1, 32'hA0A1A2A3, 4'hF, 0};
    vecs[3]  = '{1, 2'd3, 16'd0, 32'hB0B1B2B3, 1, 1, 1, 1, 32'hB0B1B2B3, 4'hF, 0};
    vecs[4]  = '{0, 2'd0, 16'd0, 32'hC0C1C2C3, 1, 1, 1, 1, 32'hC0C1C2C3, 4'hF, 0};
    vecs[5]  = '{0, 2'd0, 16'd0, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 1};
    vecs[6]  = '{0, 2'd0, 16'd0, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0};
    // k=1, L=2
    vecs[7]  = '{1, 2'd1, 16'd2, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0};
    vecs[8]  = '{0, 2'd0, 16'd0, 32'h44332211, 1, 1, 1, 1, 32'h33221100, 4'hE, 0};
    vecs[9]  = '{0, 2'd0, 16'd0, 32'h88776655, 1, 1, 1, 1, 32'h77665544, 4'hF, 0};
    vecs[10] = '{0, 2'd0, 16'd0, 32'h0,        0, 0, 1, 0, 32'h00000088, 4'h1, 0};
    vecs[11] = '{0, 2'd0, 16'd0, 32'h0,        0, 1, 1, 0, 32'h00000088, 4'h1, 0};
    vecs[12] = '{0, 2'd0, 16'd0, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 1};
    vecs[13] = '{0, 2'd0, 16'd0, 32'h0,        0, 1, 0, 0, 32'h0,        4'h0, 0};
    // L=0: no output word, done only
    vecs[14] = '{1, 2'd2, 16'd0, 32'h0,        1, 1, 0, 0, 32'h0,        4'h0, 0};
    vecs[15] = '{0, 2'd0, 16'd0, 32'h12345678, 1, 1, 0, 0, 32'h0,        4'h0, 1};
    vecs[16] = '{0, 2'd0, 16'd0, 32'h12345678, 1, 1, 0, 0, 32'h0,        4'h0, 0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", stream_o_valid, 1'b0);
    chk("rst_ready", stream_i_ready, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_state", state_o, 2'd0);
`ifdef HWPE_SINK_REALIGN_STATUS_EN
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_words", words_o, 0);
`endif
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i <= 16; i++) begin
      start_i = vecs[i].start; offset_i = vecs[i].k; line_length_i = vecs[i].len;
      stream_i_data = vecs[i].din; stream_i_valid = vecs[i].vin; stream_o_ready = vecs[i].rout;
      #1;
      chk($sformatf("vec%0d_valid", i), stream_o_valid, vecs[i].exp_vo);
      chk($sformatf("vec%0d_ready", i), stream_i_ready, vecs[i].exp_ri);
      chk($sformatf("vec%0d_done", i), done_o, vecs[i].exp_done);
      if (vecs[i].exp_vo) begin
        chk($sformatf("vec%0d_data", i), stream_o_data, vecs[i].exp_d);
        chk($sformatf("vec%0d_strb", i), stream_o_strb, vecs[i].exp_s);
      end
      @(negedge clk);
    end
    start_i = 1'b0; stream_i_valid = 1'b0;

    // clear after two words of a five-word line
    for (int i = 0; i < 5; i++) in_mem[i] = $urandom;
    start_i = 1'b1; offset_i = 2'd1; line_length_i = 16'd5;
    @(negedge clk);
    start_i = 1'b0; stream_i_valid = 1'b1; stream_o_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stream_i_data = in_mem[i];
      @(negedge clk);
    end
    stream_i_data = in_mem[2];
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    chk("clr_valid", stream_o_valid, 1'b0);
    chk("clr_ready", stream_i_ready, 1'b0);
    chk("clr_done", done_o, 1'b0);
    chk("clr_state", state_o, 2'd0);
    @(negedge clk);
    stream_i_valid = 1'b0;
    #1;
    chk("clr_no_done", done_o, 1'b0);
    @(negedge clk);
    in_mem[0] = $urandom;
    run_line(2, 1, 100, 100, 0);

    // k=3, L=4 with a 50% output ready
    for (int i = 0; i < 4; i++) in_mem[i] = $urandom;
    run_line(3, 4, 50, 100, 1);

    // status case: k=2, L=3 (words_o must end at 4)
    for (int i = 0; i < 3; i++) in_mem[i] = $urandom;
    run_line(2, 3, 100, 100, 0);

    // randomized lines
    for (int t = 0; t < 12; t++) begin
      int k, len;
      k   = $urandom_range(3);
      len = $urandom_range(8, 1);
      for (int i = 0; i < len; i++) in_mem[i] = $urandom;
      run_line(k, len, 50, 70, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
